// File: rtl/fifo_reader.sv
// fifo_reader: pulls entries from a registered-output FIFO into a 2-entry
// in-order skid buffer and presents the head entry downstream with a
// valid/ready handshake. Credit accounting covers the read that is still in
// flight, so the skid never overflows and one entry per cycle flows when the
// FIFO is non-empty and downstream is ready.
// Optional feature macro: FIFO_READER_DROP_INVALID_EN -- captured entries whose
// valid bit is clear are discarded and counted in drop_count instead of being
// forwarded. Without the macro every entry is forwarded and drop_count is 0.
module fifo_reader #(
  parameter int FlitWidth     = 82,
  parameter int ChildrenWidth = 3,
  parameter int EntryWidth    = FlitWidth + ChildrenWidth,
  parameter int DropCntWidth  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [EntryWidth-1:0]   fifo_out,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  output logic [EntryWidth-1:0]   flit_out,
  output logic                    flit_valid,
  input  logic                    flit_ready,
  output logic [DropCntWidth-1:0] drop_count
);

  localparam int ValidBit = FlitWidth - 1;

  // Skid storage: slot0 is always the head, slot1 the second entry.
  logic [EntryWidth-1:0] slot0_q, slot0_d;
  logic [EntryWidth-1:0] slot1_q, slot1_d;
  logic [1:0]            occ_q, occ_d;
  logic                  rd_pending_q;

  logic                  pop_s;
  logic                  keep_s;
  logic [2:0]            credit_s;
  logic [1:0]            occ_after_pop_s;

  assign flit_valid = (occ_q != 2'd0);
  assign flit_out   = slot0_q;
  assign pop_s      = flit_valid && flit_ready;

  // Slots already committed next cycle: held entries plus the read in flight,
  // minus the entry leaving now. pop_s implies occ_q >= 1, so no underflow.
  assign credit_s   = {1'b0, occ_q} + {2'b00, rd_pending_q} - {2'b00, pop_s};
  assign fifo_rd_en = !rst && !fifo_empty && (credit_s < 3'd2);

`ifdef FIFO_READER_DROP_INVALID_EN
  logic [DropCntWidth-1:0] drop_cnt_q, drop_cnt_d;

  assign keep_s     = rd_pending_q && fifo_out[ValidBit];
  assign drop_count = drop_cnt_q;

  // Saturating count of captured entries discarded for a clear valid bit.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (rd_pending_q && !fifo_out[ValidBit] && (drop_cnt_q != {DropCntWidth{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + {{(DropCntWidth-1){1'b0}}, 1'b1};
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= {DropCntWidth{1'b0}};
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end
`else
  assign keep_s     = rd_pending_q;
  assign drop_count = {DropCntWidth{1'b0}};
`endif

  // Skid next state: advance the head on pop, then append the capture at the
  // first free slot after that pop so simultaneous pop+capture keeps order.
  always_comb begin
    slot0_d         = slot0_q;
    slot1_d         = slot1_q;
    occ_after_pop_s = occ_q;
    occ_d           = occ_q;
    if (pop_s) begin
      slot0_d         = slot1_q;
      occ_after_pop_s = occ_q - 2'd1;
    end else begin
      occ_after_pop_s = occ_q;
    end
    if (keep_s) begin
      case (occ_after_pop_s)
        2'd0: begin
          slot0_d = fifo_out;
          occ_d   = 2'd1;
        end
        2'd1: begin
          slot1_d = fifo_out;
          occ_d   = 2'd2;
        end
        // Unreachable: the credit rule never lets a capture meet a full skid.
        default: begin
          occ_d = occ_after_pop_s;
        end
      endcase
    end else begin
      occ_d = occ_after_pop_s;
    end
  end

  // Skid, occupancy and in-flight read registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_q      <= {EntryWidth{1'b0}};
      slot1_q      <= {EntryWidth{1'b0}};
      occ_q        <= 2'd0;
      rd_pending_q <= 1'b0;
    end else begin
      slot0_q      <= slot0_d;
      slot1_q      <= slot1_d;
      occ_q        <= occ_d;
      rd_pending_q <= fifo_rd_en;
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: a FIFO model with registered read data
// feeds the DUT, every forwarded entry is checked against a scoreboard queue.
module tb_fifo_reader;

`ifdef FIFO_READER_DROP_INVALID_EN
  localparam bit DropEn = 1'b1;
  localparam int ExpFwd = 3;
  localparam int ExpDrop = 3;
`else
  localparam bit DropEn = 1'b0;
  localparam int ExpFwd = 6;
  localparam int ExpDrop = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [84:0] fifo_out = 85'd0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [84:0] flit_out;
  logic        flit_valid;
  logic        flit_ready = 1'b0;
  logic [15:0] drop_count;

  fifo_reader dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_out  (fifo_out),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .flit_out  (flit_out),
    .flit_valid(flit_valid),
    .flit_ready(flit_ready),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  logic [84:0] src_q[$];
  logic [84:0] exp_q[$];
  int          exp_drops = 0;
  logic [84:0] model_e;

  logic rst_v = 1'b1;
  logic ready_v = 1'b0;
  logic gate_v = 1'b0;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int rd_cnt, valid_cnt, fwd_cnt, first_rd, first_valid, last_valid, empty_viol;
  logic        hold_active = 1'b0;
  logic [84:0] hold_val = 85'd0;

  function automatic bit keep_f(input logic [84:0] e);
    return !DropEn || e[81];
  endfunction

  function automatic logic [84:0] mk(input logic [31:0] p, input logic v);
    logic [84:0] e;
    e = 85'd0;
    e[31:0] = p;
    e[63:32] = ~p;
    e[81] = v;
    e[84:82] = p[2:0] ^ 3'b101;
    return e;
  endfunction

  // FIFO model: read data appears the cycle after a pop request.
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      exp_q.delete();
      exp_drops = 0;
    end else if (fifo_rd_en === 1'b1 && src_q.size() != 0) begin
      model_e = src_q.pop_front();
      fifo_out <= model_e;
      if (keep_f(model_e)) exp_q.push_back(model_e);
      else if (exp_drops != 65535) exp_drops++;
    end
  end

  task automatic clear_stats();
    rd_cnt = 0; valid_cnt = 0; fwd_cnt = 0; empty_viol = 0;
    first_rd = -1; first_valid = -1; last_valid = -1;
  endtask

  // One clock: drive inputs at negedge, then observe and score outputs.
  task automatic cycle();
    logic [84:0] exp_e;
    @(negedge clk);
    rst = rst_v;
    flit_ready = ready_v;
    fifo_empty = (src_q.size() == 0) || gate_v;
    #1;
    cyc++;
    if (fifo_rd_en === 1'b1 && fifo_empty === 1'b1) empty_viol++;
    if (fifo_rd_en === 1'b1) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (flit_valid === 1'b1) begin
      valid_cnt++;
      if (first_valid < 0) first_valid = cyc;
      last_valid = cyc;
    end
    if (hold_active && flit_valid === 1'b1) begin
      checks++;
      if (flit_out !== hold_val) $display("FAIL stall_stable got %h exp %h", flit_out, hold_val);
      else passes++;
    end
    hold_active = (flit_valid === 1'b1) && (flit_ready === 1'b0);
    hold_val = flit_out;
    if (flit_valid === 1'b1 && flit_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_flit got %h exp none", flit_out);
      end else begin
        exp_e = exp_q.pop_front();
        fwd_cnt++;
        if (flit_out !== exp_e) $display("FAIL flit_data got %h exp %h", flit_out, exp_e);
        else passes++;
      end
    end
  endtask

  task automatic do_reset();
    rst_v = 1'b1; gate_v = 1'b0; ready_v = 1'b0;
    src_q.delete();
    repeat (2) cycle();
    rst_v = 1'b0;
    hold_active = 1'b0;
    clear_stats();
  endtask

  task automatic test_reset();
    rst_v = 1'b1; ready_v = 1'b1; gate_v = 1'b0;
    src_q.push_back(mk(32'h0000_00A5, 1'b1));
    repeat (2) cycle();
    checks++; if (fifo_rd_en !== 1'b0) $display("FAIL rst_rd_en got %b exp 0", fifo_rd_en); else passes++;
    checks++; if (flit_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", flit_valid); else passes++;
    checks++; if (flit_out !== 85'd0) $display("FAIL rst_flit_out got %h exp 0", flit_out); else passes++;
    checks++; if (drop_count !== 16'd0) $display("FAIL rst_drop got %0d exp 0", drop_count); else passes++;
    rst_v = 1'b0;
    clear_stats();
    cycle();
    checks++; if (fifo_rd_en !== 1'b1) $display("FAIL post_rst_rd_en got %b exp 1", fifo_rd_en); else passes++;
    repeat (5) cycle();
    checks++; if (fwd_cnt !== 1) $display("FAIL post_rst_fwd got %0d exp 1", fwd_cnt); else passes++;
  endtask

  task automatic test_single();
    logic [84:0] e;
    do_reset();
    e = 85'd0; e[81] = 1'b1; e[31:0] = 32'd5;
    ready_v = 1'b1;
    src_q.push_back(e);
    repeat (8) cycle();
    checks++; if (rd_cnt !== 1) $display("FAIL single_rd_cnt got %0d exp 1", rd_cnt); else passes++;
    checks++; if (valid_cnt !== 1) $display("FAIL single_valid_cnt got %0d exp 1", valid_cnt); else passes++;
    checks++; if (first_valid - first_rd !== 2) $display("FAIL single_latency got %0d exp 2", first_valid - first_rd); else passes++;
    checks++; if (fwd_cnt !== 1) $display("FAIL single_fwd got %0d exp 1", fwd_cnt); else passes++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    ready_v = 1'b1;
    for (int i = 1; i <= 4; i++) src_q.push_back(mk(32'(i), 1'b1));
    repeat (10) cycle();
    checks++; if (valid_cnt !== 4) $display("FAIL b2b_valid_cnt got %0d exp 4", valid_cnt); else passes++;
    checks++; if (last_valid - first_valid !== 3) $display("FAIL b2b_span got %0d exp 3", last_valid - first_valid); else passes++;
    checks++; if (fwd_cnt !== 4) $display("FAIL b2b_fwd got %0d exp 4", fwd_cnt); else passes++;
  endtask

  task automatic test_stall();
    do_reset();
    ready_v = 1'b0;
    for (int i = 1; i <= 8; i++) src_q.push_back(mk(32'(i), 1'b1));
    repeat (10) cycle();
    checks++; if (rd_cnt !== 2) $display("FAIL stall_rd_cnt got %0d exp 2", rd_cnt); else passes++;
    checks++; if (flit_valid !== 1'b1) $display("FAIL stall_valid got %b exp 1", flit_valid); else passes++;
    clear_stats();
    ready_v = 1'b1;
    repeat (20) cycle();
    checks++; if (fwd_cnt !== 8) $display("FAIL stall_fwd got %0d exp 8", fwd_cnt); else passes++;
    checks++; if (exp_q.size() !== 0) $display("FAIL stall_left got %0d exp 0", exp_q.size()); else passes++;
  endtask

  task automatic test_reset_pending();
    int n;
    do_reset();
    ready_v = 1'b1;
    src_q.push_back(mk(32'h0000_0077, 1'b1));
    n = 0;
    while (rd_cnt == 0 && n < 10) begin
      cycle();
      n++;
    end
    checks++; if (rd_cnt !== 1) $display("FAIL rstp_rd_seen got %0d exp 1", rd_cnt); else passes++;
    rst_v = 1'b1;
    cycle();
    rst_v = 1'b0;
    clear_stats();
    cycle();
    checks++; if (flit_valid !== 1'b0) $display("FAIL rstp_valid got %b exp 0", flit_valid); else passes++;
    checks++; if (flit_out !== 85'd0) $display("FAIL rstp_flit_out got %h exp 0", flit_out); else passes++;
    checks++; if (fifo_rd_en !== 1'b0) $display("FAIL rstp_rd_en got %b exp 0", fifo_rd_en); else passes++;
    checks++; if (drop_count !== 16'd0) $display("FAIL rstp_drop got %0d exp 0", drop_count); else passes++;
    repeat (5) cycle();
    checks++; if (valid_cnt !== 0) $display("FAIL rstp_no_valid got %0d exp 0", valid_cnt); else passes++;
  endtask

  task automatic test_drop();
    do_reset();
    ready_v = 1'b1;
    for (int i = 1; i <= 6; i++) src_q.push_back(mk(32'(i), (i % 2) == 1));
    repeat (15) cycle();
    checks++; if (fwd_cnt !== ExpFwd) $display("FAIL drop_fwd got %0d exp %0d", fwd_cnt, ExpFwd); else passes++;
    checks++; if (drop_count !== 16'(ExpDrop)) $display("FAIL drop_count got %0d exp %0d", drop_count, ExpDrop); else passes++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      if (src_q.size() < 4) src_q.push_back(85'({$urandom(), $urandom(), $urandom()}));
      gate_v = ~gate_v;
      ready_v = 1'($urandom_range(0, 1));
      cycle();
    end
    gate_v = 1'b0;
    ready_v = 1'b1;
    repeat (12) cycle();
    checks++; if (empty_viol !== 0) $display("FAIL rand_rd_while_empty got %0d exp 0", empty_viol); else passes++;
    checks++; if (exp_q.size() !== 0) $display("FAIL rand_left got %0d exp 0", exp_q.size()); else passes++;
    checks++; if (fwd_cnt < 100) $display("FAIL rand_fwd_low got %0d exp >=100", fwd_cnt); else passes++;
    checks++; if (drop_count !== 16'(exp_drops)) $display("FAIL rand_drop got %0d exp %0d", drop_count, exp_drops); else passes++;
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_pending();
    test_drop();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
